mod_updown_counter: RTL and testbench

Parametrised synchronous up/down counter with programmable modulus, prescaler, parallel load and wrap/saturate mode. It is the fully synchronous successor to the team's 8-bit T-flip-flop ripple counter. All state bits change on the single `clock` edge, so there is no ripple skew. It serves as the general event/timebase counter for the lab designs: dividers, display scanners and timeouts.

---
 rtl/mod_updown_counter_pkg.sv | 28 ++
 rtl/mod_updown_counter_prescaler.sv | 61 ++++++
 rtl/mod_updown_counter.sv | 118 +++++++++++
 tb/tb_mod_updown_counter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
//------------------------------------------------------------------------------
// Package     : counter_pkg
// Description : Shared constants and helpers for mod_updown_counter and its
//               prescaler: direction / bound-mode encodings and the width
//               helper used to size the prescaler count register.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  // Encodings for the 'up' input
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Encodings for the 'sat' input
  localparam logic MODE_SAT  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;

  // Bits needed to hold a prescaler count of 0..prescale-1; never below 1 so
  // the register always has a legal width.
  function automatic int pcnt_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_updown_counter_prescaler.sv
//------------------------------------------------------------------------------
// Module      : prescaler
// Description : Divides enabled cycles by PRESCALE. Emits a one-cycle 'step'
//               on the enabled cycle that completes a prescale period. The
//               partial count is held while 'en' is low.
// Revision    : 1.0 - initial release
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-low reset (clears the partial count)
//   en     in   advance the prescaler
//   clr    in   synchronous clear of the partial count (used on load)
//   step   out  one-cycle step pulse
//------------------------------------------------------------------------------
`default_nettype none

module prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_passthru
      // No state needed: every enabled cycle is a step. The owner applies
      // load priority, so clr/reset have nothing to act on here.
      logic w_unused;
      assign w_unused = &{1'b0, clock, reset, clr};
      assign step     = en;
    end else begin : g_count
      localparam int C_PW = pcnt_width(PRESCALE);
      localparam logic [C_PW-1:0] C_LAST = C_PW'(PRESCALE - 1);

      logic [C_PW-1:0] r_pcnt;
      logic            w_last;

      assign w_last = (r_pcnt == C_LAST);

      always_ff @(posedge clock) begin
        if (!reset) begin
          r_pcnt <= '0;
        end else if (clr) begin
          r_pcnt <= '0;
        end else if (en) begin
          r_pcnt <= w_last ? '0 : r_pcnt + C_PW'(1);
        end
      end

      assign step = en & w_last;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mod_updown_counter.sv
//------------------------------------------------------------------------------
// Module      : mod_updown_counter
// Description : Synchronous up/down counter with programmable modulus,
//               prescaler, parallel load (clamped) and wrap/saturate mode.
// Revision    : 1.0 - initial release
//
// Ports:
//   clock  in         rising-edge clock
//   reset  in         synchronous, active-low reset
//   en     in         count enable (advances the prescaler)
//   up     in         direction, 1 = up, 0 = down
//   sat    in         bound mode, 1 = saturate, 0 = wrap modulo MODULUS
//   load   in         parallel load strobe
//   d      in [W]     load value (clamped to MODULUS-1)
//   o      out [W]    registered count
//   tc     out        terminal count, combinational from o and up
//   wrap   out        registered one-cycle pulse on a wrapping step
//------------------------------------------------------------------------------
`default_nettype none

module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
  parameter int              PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS itself (up to 2**WIDTH) is representable.
  localparam logic [WIDTH:0] C_MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] C_TOP = (WIDTH+1)'(MODULUS - 64'd1);

  logic [WIDTH-1:0] r_o;
  logic             r_wrap;

  logic             w_step;
  logic [WIDTH:0]   w_o_ext;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_at_top;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_o_nxt;
  logic             w_wrap_nxt;
  logic             w_unused;

  prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .step  (w_step)
  );

  assign w_o_ext    = {1'b0, r_o};
  assign w_inc      = w_o_ext + (WIDTH+1)'(1);
  assign w_dec      = w_o_ext - (WIDTH+1)'(1);
  assign w_at_top   = (w_o_ext == C_TOP);
  assign w_at_zero  = (r_o == '0);
  assign w_load_val = ({1'b0, d} < C_MOD) ? d : C_TOP[WIDTH-1:0];
  // Carry/borrow bits never matter: increments stop at the top, decrements at 0.
  assign w_unused   = &{1'b0, w_inc[WIDTH], w_dec[WIDTH]};

  // Next-state mux in priority order: load, step, hold (reset in the flop).
  always_comb begin
    w_o_nxt    = r_o;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_o_nxt = w_load_val;
    end else if (w_step) begin
      if (up == DIR_UP) begin
        if (!w_at_top) begin
          w_o_nxt = w_inc[WIDTH-1:0];
        end else if (sat == MODE_WRAP) begin
          w_o_nxt    = '0;
          w_wrap_nxt = 1'b1;
        end
      end else begin
        if (!w_at_zero) begin
          w_o_nxt = w_dec[WIDTH-1:0];
        end else if (sat == MODE_WRAP) begin
          w_o_nxt    = C_TOP[WIDTH-1:0];
          w_wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_o    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_o    <= w_o_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign o    = r_o;
  assign wrap = r_wrap;
  assign tc   = (up == DIR_UP) ? w_at_top : w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_mod_updown_counter
// Description : Self-checking bench. Three counter instances (default, mod-10,
//               mod-10 with prescale 4) share one stimulus stream and are
//               compared every cycle against an integer reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_updown_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       up    = 1'b1;
  logic       sat   = 1'b0;
  logic       load  = 1'b0;
  logic [7:0] d     = 8'd0;

  logic [7:0] o0;
  logic [3:0] o1, o2;
  logic       tc0, tc1, tc2, wr0, wr1, wr2;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance
  int c_mod[3]  = '{256, 10, 10};
  int c_ps[3]   = '{1, 1, 4};
  int c_dmax[3] = '{256, 16, 16};
  int m_o[3]    = '{0, 0, 0};
  int m_pc[3]   = '{0, 0, 0};
  int m_w[3]    = '{0, 0, 0};

  always #5 clock = ~clock;

  mod_updown_counter u_def (
    .clock (clock), .reset (reset), .en (en), .up (up), .sat (sat),
    .load (load), .d (d), .o (o0), .tc (tc0), .wrap (wr0)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clock (clock), .reset (reset), .en (en), .up (up), .sat (sat),
    .load (load), .d (d[3:0]), .o (o1), .tc (tc1), .wrap (wr1)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u_p4 (
    .clock (clock), .reset (reset), .en (en), .up (up), .sat (sat),
    .load (load), .d (d[3:0]), .o (o2), .tc (tc2), .wrap (wr2)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply the counter rules to the model for one rising edge
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int dv;
      dv = int'(d) % c_dmax[k];
      if (!reset) begin
        m_o[k] = 0; m_pc[k] = 0; m_w[k] = 0;
      end else if (load) begin
        m_o[k]  = (dv < c_mod[k]) ? dv : c_mod[k] - 1;
        m_pc[k] = 0; m_w[k] = 0;
      end else begin
        m_w[k] = 0;
        if (en) begin
          m_pc[k]++;
          if (m_pc[k] == c_ps[k]) begin
            m_pc[k] = 0;
            if (up) begin
              if (m_o[k] < c_mod[k] - 1) m_o[k]++;
              else if (!sat) begin m_o[k] = 0; m_w[k] = 1; end
            end else begin
              if (m_o[k] > 0) m_o[k]--;
              else if (!sat) begin m_o[k] = c_mod[k] - 1; m_w[k] = 1; end
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int ob[3];
    int tb[3];
    int wb[3];
    ob = '{int'(o0), int'(o1), int'(o2)};
    tb = '{int'(tc0), int'(tc1), int'(tc2)};
    wb = '{int'(wr0), int'(wr1), int'(wr2)};
    for (int k = 0; k < 3; k++) begin
      int tc_exp;
      tc_exp = up ? int'(m_o[k] == c_mod[k] - 1) : int'(m_o[k] == 0);
      check($sformatf("o[%0d]", k), ob[k], m_o[k]);
      check($sformatf("wrap[%0d]", k), wb[k], m_w[k]);
      check($sformatf("tc[%0d]", k), tb[k], tc_exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset overrides en and load
    reset = 1'b0; en = 1'b1; load = 1'b1; d = 8'hAB; up = 1'b1;
    tick(3);
    check("rst_o", o0, 0);
    check("rst_wrap", wr0, 0);
    check("rst_tc_up", tc0, 0);
    up = 1'b0; #1;
    check("rst_tc_down", tc0, 1);
    up = 1'b1;

    // Count 5 up
    reset = 1'b1; load = 1'b0; en = 1'b1;
    tick(5);
    check("count5", o0, 5);

    // Wrap on modulus 10
    sat = 1'b0; load = 1'b1; d = 8'd9; en = 1'b0;
    tick(1);
    check("ld9_tc", tc1, 1);
    load = 1'b0; en = 1'b1;
    tick(1);
    check("wrap_up_o", o1, 0);
    check("wrap_up_pulse", wr1, 1);
    en = 1'b0;
    tick(1);
    check("wrap_one_cycle", wr1, 0);
    up = 1'b0; en = 1'b1;
    tick(1);
    check("wrap_dn_o", o1, 9);
    check("wrap_dn_pulse", wr1, 1);
    en = 1'b0;
    tick(1);

    // Saturate
    sat = 1'b1; up = 1'b0; load = 1'b1; d = 8'd0;
    tick(1);
    load = 1'b0; en = 1'b1;
    tick(4);
    check("sat_lo_o", o1, 0);
    check("sat_lo_wrap", wr1, 0);
    check("sat_lo_tc", tc1, 1);
    up = 1'b1; load = 1'b1; d = 8'd9;
    tick(1);
    load = 1'b0;
    tick(3);
    check("sat_hi_o", o1, 9);

    // Prescale 4 with an enable gap
    sat = 1'b0; reset = 1'b0;
    tick(1);
    reset = 1'b1; en = 1'b1;
    tick(6);
    check("ps_6en", o2, 1);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(1);
    check("ps_7en", o2, 1);
    tick(1);
    check("ps_8en", o2, 2);

    // Load clamp and load-over-enable
    en = 1'b0; load = 1'b1; d = 8'd15;
    tick(1);
    check("clamp15", o1, 9);
    load = 1'b0; reset = 1'b0;
    tick(1);
    reset = 1'b1; en = 1'b1;
    tick(3);
    load = 1'b1; d = 8'd2;
    tick(1);
    check("ld_wins", o2, 2);
    load = 1'b0;
    tick(3);
    check("ld_pcnt_clr", o2, 2);
    tick(1);
    check("ld_next_step", o2, 3);

    // Reset mid-prescale
    tick(3);
    reset = 1'b0;
    tick(1);
    check("midrst_o", o2, 0);
    reset = 1'b1;
    tick(3);
    check("midrst_3en", o2, 0);
    tick(1);
    check("midrst_4en", o2, 1);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      load  = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 9) < 7);
      up    = $urandom_range(0, 1) == 1;
      sat   = ($urandom_range(0, 3) == 0);
      d     = 8'($urandom);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
